dcache_wb_direct: RTL and testbench

Direct-mapped, write-back, write-allocate data cache placed between the Memory stage's D-cache port (`DCACHE_*`) and the external data memory. It serves word reads and writes from the pipeline. Hits complete in the same cycle. Misses hold `proc_stall` high while the controller writes back a dirty victim line and refills the line from memory.

---
 rtl/dcache_wb_direct.sv | 157 +++++++++++++++
 tb/tb_dcache_wb_direct.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_direct.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits complete in the same cycle. A miss stalls the pipeline while a dirty
// victim is written back and the line is refilled. The request is then
// replayed as a hit from IDLE. Memory strobes, address and write data are
// registered. They change together with the state register.
module dcache_wb_direct #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int IW        = $clog2(LINES);
    localparam int TW        = 28 - IW;
    localparam int LINE_BITS = WORDS * 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [LINES-1:0]       valid_r;
    logic [LINES-1:0]       dirty_r;
    logic [TW-1:0]          tag_arr_r  [LINES];
    logic [LINE_BITS-1:0]   data_arr_r [LINES];

    logic                   mem_read_r;
    logic                   mem_write_r;
    logic [27:0]            mem_addr_r;
    logic [127:0]           mem_wdata_r;

    logic [IW-1:0]          idx_s;
    logic [TW-1:0]          tag_s;
    logic [1:0]             off_s;
    logic                   req_s;
    logic                   hit_s;
    logic                   wr_hit_s;
    logic [LINE_BITS-1:0]   line_s;
    logic [31:0]            word_s;
    logic [31:0]            rdata_s;
    logic                   stall_s;

    assign idx_s    = proc_addr[IW+1:2];
    assign tag_s    = proc_addr[29:IW+2];
    assign off_s    = proc_addr[1:0];
    assign req_s    = proc_read | proc_write;
    assign line_s   = data_arr_r[idx_s];
    assign word_s   = line_s[{off_s, 5'd0} +: 32];
    assign hit_s    = valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s);
    // Simultaneous read and write is a write.
    assign wr_hit_s = (state_r == ST_IDLE) && proc_write && hit_s;

    // Load data and stall: hits are answered combinationally from the array.
    always_comb begin
        rdata_s = 32'd0;
        stall_s = 1'b1;
        if ((state_r == ST_IDLE) && hit_s) begin
            rdata_s = word_s;
        end else begin
            rdata_s = 32'd0;
        end
        case (state_r)
            ST_IDLE: stall_s = req_s && !hit_s;
            default: stall_s = 1'b1;
        endcase
    end

    // Control FSM with valid/dirty bits and the registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            valid_r     <= {LINES{1'b0}};
            dirty_r     <= {LINES{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 28'd0;
            mem_wdata_r <= 128'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && hit_s) begin
                        if (proc_write) begin
                            dirty_r[idx_s] <= 1'b1;
                        end
                    end else if (req_s && valid_r[idx_s] && dirty_r[idx_s]) begin
                        state_r     <= ST_WRITEBACK;
                        mem_write_r <= 1'b1;
                        mem_addr_r  <= {tag_arr_r[idx_s], idx_s};
                        mem_wdata_r <= line_s;
                    end else if (req_s) begin
                        state_r    <= ST_ALLOCATE;
                        mem_read_r <= 1'b1;
                        mem_addr_r <= {tag_s, idx_s};
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        state_r     <= ST_ALLOCATE;
                        mem_write_r <= 1'b0;
                        mem_read_r  <= 1'b1;
                        mem_addr_r  <= {tag_s, idx_s};
                        mem_wdata_r <= 128'd0;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        state_r        <= ST_IDLE;
                        mem_read_r     <= 1'b0;
                        mem_addr_r     <= 28'd0;
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    mem_addr_r  <= 28'd0;
                    mem_wdata_r <= 128'd0;
                end
            endcase
        end
    end

    // Tag and data arrays: refill writes a whole line, a write hit updates one word.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_ALLOCATE) && mem_ready) begin
            tag_arr_r[idx_s]  <= tag_s;
            data_arr_r[idx_s] <= mem_rdata;
        end else if (!rst && wr_hit_s) begin
            data_arr_r[idx_s][{off_s, 5'd0} +: 32] <= proc_wdata;
        end
    end

    assign proc_rdata = rdata_s;
    assign proc_stall = stall_s;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_dcache_wb_direct.sv
// Bench for dcache_wb_direct: a table of pipeline accesses is replayed
// against a behavioural memory. Expected load results and expected memory
// transactions are queued when an access is driven. They are checked when
// the cache or the memory model produces them.
module tb_dcache_wb_direct;

    localparam int L_LAT = 4;
    localparam int W_LAT = 3;
    localparam int CLEAN = L_LAT + 1;
    localparam int DIRTY = W_LAT + L_LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rdata;
        int          exp_stall;
        logic        has_wb;
        logic [27:0] wb_line;
        logic [1:0]  wb_word;
        logic [31:0] wb_data;
        logic        has_rd;
        logic [27:0] rd_line;
        string       name;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
        int          stall;
        string       name;
    } exp_t;

    typedef struct {
        logic [27:0] line;
        logic [1:0]  word;
        logic [31:0] data;
    } wb_t;

    vec_t        vq[$];
    exp_t        exp_q[$];
    wb_t         exp_wb_q[$];
    logic [27:0] exp_rd_q[$];

    logic [127:0] mem_model [256];
    int rcnt = 0;
    int wcnt = 0;

    dcache_wb_direct #(.LINES(8), .WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: fixed write-back and refill latencies, one-cycle ready pulse.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_read || mem_write) begin
            check("strobes_exclusive", {127'd0, mem_read && mem_write}, 128'd0);
        end
        if (rst) begin
            rcnt = 0;
            wcnt = 0;
        end else if (mem_write) begin
            rcnt = 0;
            wcnt++;
            if (wcnt == W_LAT) begin
                mem_ready = 1'b1;
                if (exp_wb_q.size() == 0) begin
                    check("wb_unexpected", 128'd1, 128'd0);
                end else begin
                    wb_t e;
                    e = exp_wb_q.pop_front();
                    check("wb_addr", {100'd0, mem_addr}, {100'd0, e.line});
                    check("wb_word", {96'd0, mem_wdata[e.word*32 +: 32]}, {96'd0, e.data});
                end
                mem_model[mem_addr[7:0]] = mem_wdata;
            end
        end else if (mem_read) begin
            wcnt = 0;
            rcnt++;
            if (rcnt == L_LAT) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model[mem_addr[7:0]];
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 128'd1, 128'd0);
                end else begin
                    logic [27:0] a;
                    a = exp_rd_q.pop_front();
                    check("rd_addr", {100'd0, mem_addr}, {100'd0, a});
                end
            end
        end else begin
            rcnt = 0;
            wcnt = 0;
        end
    end

    function automatic vec_t mk(input logic rd, input logic wr, input logic [29:0] addr,
                                input logic [31:0] wdata, input logic chk, input logic [31:0] er,
                                input int es, input logic hw, input logic [27:0] wl,
                                input logic [1:0] ww, input logic [31:0] wd,
                                input logic hr, input logic [27:0] rl, input string name);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.chk = chk;
        v.exp_rdata = er; v.exp_stall = es; v.has_wb = hw; v.wb_line = wl;
        v.wb_word = ww; v.wb_data = wd; v.has_rd = hr; v.rd_line = rl; v.name = name;
        return v;
    endfunction

    // Drive one access, hold it while stalled, then score stall count and load data.
    task automatic do_access(input vec_t v);
        int   stalls;
        exp_t e;
        e.chk = v.chk; e.rdata = v.exp_rdata; e.stall = v.exp_stall; e.name = v.name;
        exp_q.push_back(e);
        if (v.has_wb) exp_wb_q.push_back('{v.wb_line, v.wb_word, v.wb_data});
        if (v.has_rd) exp_rd_q.push_back(v.rd_line);
        @(negedge clk);
        proc_read  = v.rd;
        proc_write = v.wr;
        proc_addr  = v.addr;
        proc_wdata = v.wdata;
        #1;
        stalls = 0;
        while (proc_stall !== 1'b0 && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        e = exp_q.pop_front();
        if (stalls >= 100) begin
            check({e.name, "_timeout"}, 128'd1, 128'd0);
        end else begin
            check({e.name, "_stall"}, 128'(stalls), 128'(e.stall));
            if (e.chk) check({e.name, "_rdata"}, {96'd0, proc_rdata}, {96'd0, e.rdata});
        end
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            for (int j = 0; j < 4; j++) begin
                mem_model[a][j*32 +: 32] = 32'hA000_0000 | (32'(a) << 8) | 32'(j);
            end
        end
        mem_model[4][31:0] = 32'hDEAD_BEEF;
        mem_ready  = 1'b0;
        mem_rdata  = 128'd0;
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = 30'd0;
        proc_wdata = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stall",     {127'd0, proc_stall}, 128'd0);
        check("reset_mem_read",  {127'd0, mem_read},   128'd0);
        check("reset_mem_write", {127'd0, mem_write},  128'd0);
        check("reset_mem_addr",  {100'd0, mem_addr},   128'd0);
        check("reset_mem_wdata", mem_wdata,            128'd0);
        check("reset_rdata",     {96'd0, proc_rdata},  128'd0);

        vq.push_back(mk(1, 0, 30'h10, 32'h0,         1, 32'hDEADBEEF, CLEAN, 0, 28'h0,  2'd0, 32'h0,         1, 28'h04, "rd_miss_clean"));
        vq.push_back(mk(1, 0, 30'h10, 32'h0,         1, 32'hDEADBEEF, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_hit"));
        vq.push_back(mk(0, 1, 30'h11, 32'h12345678,  0, 32'h0,        0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "wr_hit"));
        vq.push_back(mk(1, 0, 30'h11, 32'h0,         1, 32'h12345678, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_after_wr"));
        vq.push_back(mk(1, 0, 30'h91, 32'h0,         1, 32'hA0002401, DIRTY, 1, 28'h04, 2'd1, 32'h12345678,  1, 28'h24, "rd_miss_dirty"));
        vq.push_back(mk(0, 1, 30'h08, 32'hA5A5A5A5,  0, 32'h0,        CLEAN, 0, 28'h0,  2'd0, 32'h0,         1, 28'h02, "wr_miss_clean"));
        vq.push_back(mk(1, 0, 30'h08, 32'h0,         1, 32'hA5A5A5A5, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_wr_alloc"));
        vq.push_back(mk(1, 0, 30'h88, 32'h0,         1, 32'hA0002200, DIRTY, 1, 28'h02, 2'd0, 32'hA5A5A5A5,  1, 28'h22, "evict_wr_alloc"));
        vq.push_back(mk(1, 1, 30'h89, 32'h5A5A0001,  0, 32'h0,        0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rdwr_hit"));
        vq.push_back(mk(1, 0, 30'h89, 32'h0,         1, 32'h5A5A0001, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_after_rdwr"));
        vq.push_back(mk(1, 0, 30'h08, 32'h0,         1, 32'hA5A5A5A5, DIRTY, 1, 28'h22, 2'd1, 32'h5A5A0001,  1, 28'h02, "wrap_back"));
        vq.push_back(mk(1, 0, 30'h0A, 32'h0,         1, 32'hA0000202, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_hit_word2"));
        vq.push_back(mk(1, 0, 30'h91, 32'h0,         1, 32'hA0002401, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_hit_idx4"));
        vq.push_back(mk(1, 0, 30'h93, 32'h0,         1, 32'hA0002403, 0,     0, 28'h0,  2'd0, 32'h0,         0, 28'h0,  "rd_hit_word3"));

        for (int i = 0; i < vq.size(); i++) begin
            do_access(vq[i]);
        end

        // Reset in the second ALLOCATE cycle abandons the refill.
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h18;
        @(posedge clk);
        #1;
        check("rst_mid_alloc_entered", {127'd0, mem_read}, 128'd1);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        proc_read = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_mem_read",  {127'd0, mem_read},   128'd0);
        check("rst_mid_mem_write", {127'd0, mem_write},  128'd0);
        check("rst_mid_stall",     {127'd0, proc_stall}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        do_access(mk(1, 0, 30'h18, 32'h0, 1, 32'hA0000600, CLEAN, 0, 28'h0, 2'd0, 32'h0, 1, 28'h06, "rst_reread_miss"));
        do_access(mk(1, 0, 30'h10, 32'h0, 1, 32'hDEADBEEF, CLEAN, 0, 28'h0, 2'd0, 32'h0, 1, 28'h04, "rst_cleared_valid"));

        repeat (2) @(posedge clk);
        check("rd_queue_drained", 128'(exp_rd_q.size()), 128'd0);
        check("wb_queue_drained", 128'(exp_wb_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
